// File: rtl/nvme_doorbell_writer.sv
// Turns NVMe SQ-tail / CQ-head doorbell requests into single-DW MemWr TLPs on the 128-bit RQ stream.
// Optional DB_CNT_EN macro adds per-doorbell completion counters (sq_db_cnt, cq_db_cnt).
module nvme_doorbell_writer #(
   parameter int          C_DATA_WIDTH        = 128,
   parameter int          KEEP_WIDTH          = C_DATA_WIDTH/32,
   parameter int          AXI4_RQ_TUSER_WIDTH = 62,
   parameter logic [63:0] BAR0_BASE           = 64'h0000_0000_F000_0000,
   parameter int          DSTRD               = 0,
   parameter int          QID                 = 0,
   parameter int          QDEPTH_LOG2         = 5
)(
   input  logic                           user_clk,
   input  logic                           user_reset,
   input  logic                           user_lnk_up,
   input  logic                           write_sqtdbl,
   input  logic [63:0]                    sqt_addr,
   input  logic                           write_cqhdbl,
   input  logic [63:0]                    cqh_addr,
`ifdef DB_CNT_EN
   output logic [31:0]                    sq_db_cnt,
   output logic [31:0]                    cq_db_cnt,
`endif
   output logic                           write_sqtdbl_done,
   output logic                           write_cqhdbl_done,
   output logic [C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
   output logic [KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
   output logic                           s_axis_rq_tlast,
   output logic [AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
   output logic                           s_axis_rq_tvalid,
   input  logic                           s_axis_rq_tready
);

   localparam logic [63:0] DB_STRIDE  = 64'd4 << DSTRD;
   localparam logic [63:0] SQ_DB_ADDR = BAR0_BASE + 64'h1000 + 64'(2*QID) * DB_STRIDE;
   localparam logic [63:0] CQ_DB_ADDR = BAR0_BASE + 64'h1000 + 64'(2*QID+1) * DB_STRIDE;

   typedef enum logic [1:0] {IDLE, DESC, DATA} state_t;

   state_t      state_reg, state_next;
   logic        sq_pend_reg, sq_pend_next;
   logic        cq_pend_reg, cq_pend_next;
   logic [15:0] sq_val_reg, sq_val_next;
   logic [15:0] cq_val_reg, cq_val_next;
   logic [15:0] cur_val_reg, cur_val_next;
   logic        sel_cq_reg, sel_cq_next;
   logic [7:0]  tag_reg, tag_next;
   logic        sq_done_reg, sq_done_next;
   logic        cq_done_reg, cq_done_next;

   // Only the low queue-index bits of the counts are meaningful.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{sqt_addr[63:QDEPTH_LOG2], cqh_addr[63:QDEPTH_LOG2]};

   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         state_reg   <= IDLE;
         sq_pend_reg <= 1'b0;
         cq_pend_reg <= 1'b0;
         sq_val_reg  <= '0;
         cq_val_reg  <= '0;
         cur_val_reg <= '0;
         sel_cq_reg  <= 1'b0;
         tag_reg     <= '0;
         sq_done_reg <= 1'b0;
         cq_done_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         sq_pend_reg <= sq_pend_next;
         cq_pend_reg <= cq_pend_next;
         sq_val_reg  <= sq_val_next;
         cq_val_reg  <= cq_val_next;
         cur_val_reg <= cur_val_next;
         sel_cq_reg  <= sel_cq_next;
         tag_reg     <= tag_next;
         sq_done_reg <= sq_done_next;
         cq_done_reg <= cq_done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      sq_pend_next = sq_pend_reg;
      cq_pend_next = cq_pend_reg;
      sq_val_next  = sq_val_reg;
      cq_val_next  = cq_val_reg;
      cur_val_next = cur_val_reg;
      sel_cq_next  = sel_cq_reg;
      tag_next     = tag_reg;
      sq_done_next = 1'b0;
      cq_done_next = 1'b0;
      if (!user_lnk_up) begin
         state_next   = IDLE;
         sq_pend_next = 1'b0;
         cq_pend_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (sq_pend_reg) begin
                  sel_cq_next  = 1'b0;
                  cur_val_next = sq_val_reg;
                  sq_pend_next = 1'b0;
                  state_next   = DESC;
               end else if (cq_pend_reg) begin
                  sel_cq_next  = 1'b1;
                  cur_val_next = cq_val_reg;
                  cq_pend_next = 1'b0;
                  state_next   = DESC;
               end
            end
            DESC: if (s_axis_rq_tready) state_next = DATA;
            DATA: begin
               if (s_axis_rq_tready) begin
                  state_next   = IDLE;
                  tag_next     = tag_reg + 8'd1;
                  sq_done_next = !sel_cq_reg;
                  cq_done_next = sel_cq_reg;
               end
            end
            default: state_next = IDLE;
         endcase
         // Capture after selection so a same-cycle request keeps the flag set.
         if (write_sqtdbl) begin
            sq_pend_next = 1'b1;
            sq_val_next  = 16'(sqt_addr[QDEPTH_LOG2-1:0]);
         end
         if (write_cqhdbl) begin
            cq_pend_next = 1'b1;
            cq_val_next  = 16'(cqh_addr[QDEPTH_LOG2-1:0]);
         end
      end
   end

   always_comb begin
      s_axis_rq_tdata  = '0;
      s_axis_rq_tkeep  = '0;
      s_axis_rq_tlast  = 1'b0;
      s_axis_rq_tuser  = '0;
      s_axis_rq_tvalid = 1'b0;
      case (state_reg)
         DESC: begin
            s_axis_rq_tvalid        = 1'b1;
            s_axis_rq_tkeep         = '1;
            s_axis_rq_tuser[3:0]    = 4'hF;
            s_axis_rq_tdata[63:2]   = sel_cq_reg ? CQ_DB_ADDR[63:2] : SQ_DB_ADDR[63:2];
            s_axis_rq_tdata[74:64]  = 11'd1;
            s_axis_rq_tdata[78:75]  = 4'b0001;
            s_axis_rq_tdata[103:96] = tag_reg;
         end
         DATA: begin
            s_axis_rq_tvalid       = 1'b1;
            s_axis_rq_tlast        = 1'b1;
            s_axis_rq_tkeep[0]     = 1'b1;
            s_axis_rq_tuser[3:0]   = 4'hF;
            s_axis_rq_tdata[15:0]  = cur_val_reg;
         end
         default: ;
      endcase
   end

   assign write_sqtdbl_done = sq_done_reg;
   assign write_cqhdbl_done = cq_done_reg;

`ifdef DB_CNT_EN
   // Counters survive link-down; only user_reset clears them.
   always_ff @(posedge user_clk or posedge user_reset) begin
      if (user_reset) begin
         sq_db_cnt <= '0;
         cq_db_cnt <= '0;
      end else begin
         if (sq_done_reg) sq_db_cnt <= sq_db_cnt + 32'd1;
         if (cq_done_reg) cq_db_cnt <= cq_db_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_nvme_doorbell_writer.sv
// Directed self-checking bench for nvme_doorbell_writer; define DB_CNT_EN to also check the counters.
module tb_nvme_doorbell_writer;

   logic         user_clk = 1'b0;
   logic         user_reset;
   logic         user_lnk_up;
   logic         write_sqtdbl;
   logic [63:0]  sqt_addr;
   logic         write_cqhdbl;
   logic [63:0]  cqh_addr;
   logic         write_sqtdbl_done;
   logic         write_cqhdbl_done;
   logic [127:0] s_axis_rq_tdata;
   logic [3:0]   s_axis_rq_tkeep;
   logic         s_axis_rq_tlast;
   logic [61:0]  s_axis_rq_tuser;
   logic         s_axis_rq_tvalid;
   logic         s_axis_rq_tready;
`ifdef DB_CNT_EN
   logic [31:0]  sq_db_cnt;
   logic [31:0]  cq_db_cnt;
`endif

   int       n_cmp = 0;
   int       n_err = 0;
   logic [7:0] exp_tag = 8'd0;
   int       exp_sq_cnt = 0;
   int       exp_cq_cnt = 0;
   logic [127:0] held;

   localparam logic [63:0] SQ_ADDR = 64'h0000_0000_F000_1000;
   localparam logic [63:0] CQ_ADDR = 64'h0000_0000_F000_1004;

   always #5 user_clk = ~user_clk;

   nvme_doorbell_writer dut (
      .user_clk          (user_clk),
      .user_reset        (user_reset),
      .user_lnk_up       (user_lnk_up),
      .write_sqtdbl      (write_sqtdbl),
      .sqt_addr          (sqt_addr),
      .write_cqhdbl      (write_cqhdbl),
      .cqh_addr          (cqh_addr),
`ifdef DB_CNT_EN
      .sq_db_cnt         (sq_db_cnt),
      .cq_db_cnt         (cq_db_cnt),
`endif
      .write_sqtdbl_done (write_sqtdbl_done),
      .write_cqhdbl_done (write_cqhdbl_done),
      .s_axis_rq_tdata   (s_axis_rq_tdata),
      .s_axis_rq_tkeep   (s_axis_rq_tkeep),
      .s_axis_rq_tlast   (s_axis_rq_tlast),
      .s_axis_rq_tuser   (s_axis_rq_tuser),
      .s_axis_rq_tvalid  (s_axis_rq_tvalid),
      .s_axis_rq_tready  (s_axis_rq_tready)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   function automatic logic [127:0] desc(input logic [63:0] a, input logic [7:0] t);
      logic [127:0] d;
      d          = '0;
      d[63:2]    = a[63:2];
      d[74:64]   = 11'd1;
      d[78:75]   = 4'b0001;
      d[103:96]  = t;
      return d;
   endfunction

   task automatic wait_tvalid(input string tag);
      int n = 0;
      while (!s_axis_rq_tvalid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_tvalid_within_budget"}, s_axis_rq_tvalid, 1'b1);
   endtask

   task automatic req_sq(input logic [63:0] v);
      sqt_addr     = v;
      write_sqtdbl = 1'b1;
      tick();
      write_sqtdbl = 1'b0;
   endtask

   // Expects tready=1; walks one TLP through both beats and its done pulse.
   task automatic check_tlp(input string tag, input bit is_cq, input logic [15:0] val);
      wait_tvalid(tag);
      chk({tag, "_desc"}, s_axis_rq_tdata, desc(is_cq ? CQ_ADDR : SQ_ADDR, exp_tag));
      chk({tag, "_desc_keep_last_user"}, {s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tuser},
          {4'hF, 1'b0, 62'hF});
      tick();
      chk({tag, "_data"}, s_axis_rq_tdata, 128'(val));
      chk({tag, "_data_valid_keep_last_user"},
          {s_axis_rq_tvalid, s_axis_rq_tkeep, s_axis_rq_tlast, s_axis_rq_tuser},
          {1'b1, 4'h1, 1'b1, 62'hF});
      tick();
      chk({tag, "_done"}, {write_sqtdbl_done, write_cqhdbl_done}, {!is_cq, is_cq});
      tick();
      chk({tag, "_done_one_cycle"}, {write_sqtdbl_done, write_cqhdbl_done}, 2'b00);
      exp_tag = exp_tag + 8'd1;
      if (is_cq) exp_cq_cnt++; else exp_sq_cnt++;
   endtask

   task automatic check_idle(input string tag, input int cycles);
      for (int i = 0; i < cycles; i++) begin
         chk(tag, s_axis_rq_tvalid, 1'b0);
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      user_reset = 1'b1; user_lnk_up = 1'b1; s_axis_rq_tready = 1'b1;
      write_sqtdbl = 1'b0; write_cqhdbl = 1'b0; sqt_addr = '0; cqh_addr = '0;
      tick(); tick(); tick();
      chk("reset_outputs",
          {s_axis_rq_tvalid, s_axis_rq_tlast, s_axis_rq_tkeep, write_sqtdbl_done, write_cqhdbl_done},
          8'h00);
      chk("reset_tdata_tuser", {s_axis_rq_tdata, s_axis_rq_tuser[61:0]}, '0);
      user_reset = 1'b0;
      tick();

      // 1: single SQ doorbell
      req_sq(64'd1);
      check_tlp("t1_sq", 1'b0, 16'h1);

      // 2: simultaneous SQ and CQ, SQ goes first
      sqt_addr = 64'd3; cqh_addr = 64'd7;
      write_sqtdbl = 1'b1; write_cqhdbl = 1'b1;
      tick();
      write_sqtdbl = 1'b0; write_cqhdbl = 1'b0;
      check_tlp("t2_sq", 1'b0, 16'h3);
      check_tlp("t2_cq", 1'b1, 16'h7);
      check_idle("t2_no_extra", 3);

      // 3: backpressure in both beats
      s_axis_rq_tready = 1'b0;
      req_sq(64'd9);
      wait_tvalid("t3");
      held = desc(SQ_ADDR, exp_tag);
      for (int i = 0; i < 5; i++) begin
         chk("t3_desc_stall", {s_axis_rq_tvalid, s_axis_rq_tlast, s_axis_rq_tdata}, {1'b1, 1'b0, held});
         tick();
      end
      s_axis_rq_tready = 1'b1;
      tick();
      s_axis_rq_tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("t3_data_stall", {s_axis_rq_tvalid, s_axis_rq_tlast, s_axis_rq_tkeep, s_axis_rq_tdata},
             {1'b1, 1'b1, 4'h1, 128'h9});
         chk("t3_no_done_while_stalled", write_sqtdbl_done, 1'b0);
         tick();
      end
      s_axis_rq_tready = 1'b1;
      tick();
      chk("t3_done", {write_sqtdbl_done, write_cqhdbl_done}, 2'b10);
      tick();
      chk("t3_done_one_cycle", write_sqtdbl_done, 1'b0);
      exp_tag = exp_tag + 8'd1; exp_sq_cnt++;
      check_idle("t3_single_tlp", 3);

      // 4: value wrap and CQ coalescing while an SQ TLP is stalled
      s_axis_rq_tready = 1'b0;
      req_sq(64'd33);
      wait_tvalid("t4");
      cqh_addr = 64'd4; write_cqhdbl = 1'b1;
      tick();
      cqh_addr = 64'd5;
      tick();
      write_cqhdbl = 1'b0;
      s_axis_rq_tready = 1'b1;
      check_tlp("t4_sq_wrap", 1'b0, 16'h1);
      check_tlp("t4_cq_coalesced", 1'b1, 16'h5);
      check_idle("t4_single_cq", 4);

      // link down flushes in-flight TLP and ignores requests; tag preserved
      s_axis_rq_tready = 1'b0;
      req_sq(64'd10);
      wait_tvalid("lnk");
      user_lnk_up = 1'b0;
      tick();
      chk("lnk_flush_tvalid", s_axis_rq_tvalid, 1'b0);
      req_sq(64'd5);
      user_lnk_up = 1'b1;
      s_axis_rq_tready = 1'b1;
      check_idle("lnk_req_ignored", 5);
      chk("lnk_no_done", {write_sqtdbl_done, write_cqhdbl_done}, 2'b00);
      req_sq(64'd6);
      check_tlp("lnk_tag_kept", 1'b0, 16'h6);

      // 5: asynchronous reset mid-DATA
      s_axis_rq_tready = 1'b0;
      req_sq(64'd2);
      wait_tvalid("t5");
      s_axis_rq_tready = 1'b1;
      tick();
      s_axis_rq_tready = 1'b0;
      chk("t5_in_data", s_axis_rq_tlast, 1'b1);
      #2 user_reset = 1'b1;
      #1 chk("t5_async_tvalid_drop", s_axis_rq_tvalid, 1'b0);
      tick();
      chk("t5_no_done", {write_sqtdbl_done, write_cqhdbl_done}, 2'b00);
      user_reset = 1'b0;
      s_axis_rq_tready = 1'b1;
      exp_tag = 8'd0; exp_sq_cnt = 0; exp_cq_cnt = 0;
      tick();
      chk("t5_no_done_after", {write_sqtdbl_done, write_cqhdbl_done, s_axis_rq_tvalid}, 3'b000);
      req_sq(64'd4);
      check_tlp("t5_after_reset_tag0", 1'b0, 16'h4);

`ifdef DB_CNT_EN
      // 6: doorbell counters
      req_sq(64'd11); check_tlp("t6_sq_a", 1'b0, 16'd11);
      req_sq(64'd12); check_tlp("t6_sq_b", 1'b0, 16'd12);
      cqh_addr = 64'd2; write_cqhdbl = 1'b1; tick(); write_cqhdbl = 1'b0;
      check_tlp("t6_cq_a", 1'b1, 16'd2);
      cqh_addr = 64'd3; write_cqhdbl = 1'b1; tick(); write_cqhdbl = 1'b0;
      check_tlp("t6_cq_b", 1'b1, 16'd3);
      chk("t6_sq_cnt", sq_db_cnt, 32'(exp_sq_cnt));
      chk("t6_cq_cnt", cq_db_cnt, 32'(exp_cq_cnt));
      user_lnk_up = 1'b0;
      tick();
      user_lnk_up = 1'b1;
      tick();
      chk("t6_sq_cnt_lnk", sq_db_cnt, 32'd3);
      chk("t6_cq_cnt_lnk", cq_db_cnt, 32'd2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/nvme_doorbell_writer.md
Name: nvme_doorbell_writer

Overview:
- Downstream of the NVMe controller FSM.
- Turns write_sqtdbl/write_cqhdbl requests into single-DW PCIe Memory Write TLPs on the AXI4-Stream RQ interface (128-bit, descriptor beat + data beat).
- Targets the NVMe SQ Tail / CQ Head doorbell registers in BAR0.
- Returns one-cycle done pulses to the controller.

Parameters:
- C_DATA_WIDTH, 128, RQ data width; only 128 supported.
- KEEP_WIDTH, C_DATA_WIDTH/32, tkeep width.
- AXI4_RQ_TUSER_WIDTH, 62, RQ tuser width.
- BAR0_BASE, 64'h0000_0000_F000_0000, SSD BAR0 bus address.
- DSTRD, 0, CAP.DSTRD doorbell stride exponent.
- QID, 0, queue ID; 0 = admin.
- QDEPTH_LOG2, 5, log2 of queue depth; doorbell value wraps at 2^QDEPTH_LOG2.

Ports:
- user_clk  in  1  clock
- user_reset  in  1  asynchronous active-high reset
- user_lnk_up  in  1  link up; low = synchronous flush
- write_sqtdbl  in  1  one-cycle request: write SQ tail doorbell
- sqt_addr  in  64  SQ tail count, sampled when write_sqtdbl=1
- write_cqhdbl  in  1  one-cycle request: write CQ head doorbell
- cqh_addr  in  64  CQ head count, sampled when write_cqhdbl=1
- write_sqtdbl_done  out  1  one-cycle pulse: SQ doorbell TLP fully accepted
- write_cqhdbl_done  out  1  one-cycle pulse: CQ doorbell TLP fully accepted
- s_axis_rq_tdata  out  C_DATA_WIDTH  RQ data
- s_axis_rq_tkeep  out  KEEP_WIDTH  RQ dword keep
- s_axis_rq_tlast  out  1  RQ last beat
- s_axis_rq_tuser  out  AXI4_RQ_TUSER_WIDTH  RQ sideband
- s_axis_rq_tvalid  out  1  RQ valid
- s_axis_rq_tready  in  1  RQ ready (only bit 0 used)

Behaviour:
Reset:
- All outputs 0, state IDLE, pending flags 0, tag counter 0.
- Reset is asynchronous; tvalid drops immediately, even mid-TLP.

Addresses:
- SQ doorbell addr = BAR0_BASE + 0x1000 + (2*QID)*(4<<DSTRD).
- CQ doorbell addr = BAR0_BASE + 0x1000 + (2*QID+1)*(4<<DSTRD).
- Defaults: 0xF000_1000 and 0xF000_1004.

Capture:
- On write_sqtdbl: sq_pend=1, sq_val = sqt_addr[QDEPTH_LOG2-1:0], zero-extended to 16 bits. cqh likewise into cq_pend/cq_val.
- Capture happens in any state, including while a TLP for the same type is in flight.
- A new request of the same type while already pending overwrites the value; only one TLP and one done pulse result (coalescing).

FSM states: IDLE, DESC, DATA.
- IDLE: if sq_pend, select SQ, else if cq_pend, select CQ. On selection, clear that pend flag and latch addr/value/tag → DESC. SQ has priority when both are pending.
- DESC: tvalid=1, tlast=0, tkeep=4'hF, tdata = descriptor. On tready → DATA.
- DATA: tvalid=1, tlast=1, tkeep=4'h1, tdata[31:0] = {16'h0, val}, upper bits 0. On tready → IDLE, pulse the matching done next cycle, tag increments mod 256.
- Back-to-back: IDLE costs 1 cycle between TLPs; minimum 3 cycles per TLP with tready=1.
- Done latency: done pulses in the cycle after DATA acceptance (registered).

Descriptor layout:
- [1:0] = 00; [63:2] = addr[63:2].
- [74:64] = 11'd1; [78:75] = 4'b0001 (MemWr).
- [79] = 0; [95:80] = 0; [103:96] = tag.
- [119:104] = 0; [120] = 0; [123:121] = 0; [126:124] = 0; [127] = 0.

tuser:
- [3:0] first_be = 4'hF while tvalid; [7:4] last_be = 0; all other bits 0.

AXIS rule:
- tdata/tkeep/tlast/tuser stay stable while tvalid && !tready.

user_lnk_up low:
- Synchronously clears pend flags, tvalid and done; state → IDLE; tag preserved.
- Requests arriving while the link is down are ignored.

Simultaneous events:
- A capture and a selection of the same type in one cycle: the capture wins; pend stays 1 holding the new value.

Optional Feature:
- DB_CNT_EN defined: adds outputs sq_db_cnt [31:0] and cq_db_cnt [31:0].
  - Each increments on its done pulse, wraps at 2^32, resets to 0 on user_reset.
  - Each is not cleared by link down.
- DB_CNT_EN undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
1. write_sqtdbl with sqt_addr=1, tready=1 → beat0 addr 0xF000_1000, dword count 1, type 0001, tag 0; beat1 tdata[31:0]=0x1, tkeep=1, tlast=1; write_sqtdbl_done one cycle later.
2. write_sqtdbl and write_cqhdbl in the same cycle (values 3, 7) → SQ TLP (0xF000_1000, data 3) then CQ TLP (0xF000_1004, data 7, tag 1); two done pulses in order.
3. tready low for 5 cycles in DESC, then 4 cycles in DATA → tvalid held and beats stable throughout; exactly one TLP; single done.
4. Wrap: sqt_addr=33 with QDEPTH_LOG2=5 → data 0x1. Two write_cqhdbl (values 4, 5) while an SQ TLP is in flight → one CQ TLP with data 5, one done.
5. user_reset asserted during DATA with tready=0 → tvalid 0 immediately; no done. After release, a new request gets tag 0 and a full TLP.
6. DB_CNT_EN: 3 SQ + 2 CQ doorbells → sq_db_cnt=3, cq_db_cnt=2; user_lnk_up pulse low → counts unchanged.
